// File: rtl/activation_pkg.sv
// Shared fixed-point formats and table geometry for the activation stage.
// Q8.8 in, unsigned Q8.8 out; the table covers |x| < 8.0 in steps of 1/32.
package activation_pkg;
  localparam int DATA_W      = 16;
  localparam int FRAC_W      = 8;
  localparam int SIG_ONE     = 256;
  localparam int SAT_LIMIT   = 2048;
  localparam int LUT_DEPTH   = 256;
  localparam int LUT_IDX_LSB = 3;
  localparam int LUT_W       = 9;
  localparam int IDX_W       = $clog2(LUT_DEPTH);
  localparam int MAG_W       = IDX_W + LUT_IDX_LSB;
endpackage

// File: rtl/sigmoid_rom.sv
// Positive half of the logistic curve: t = round(256 / (1 + exp(-idx/32))).
// Entries 165..199 are 255 and 200..255 are 256, so those collapse into shared arms.
module sigmoid_rom
  import activation_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [LUT_W-1:0] t
);

  always_comb begin
    t = LUT_W'(SIG_ONE);
    case (idx)
      8'd0: t = 9'd128; 8'd1: t = 9'd130; 8'd2: t = 9'd132; 8'd3: t = 9'd134;
      8'd4: t = 9'd136; 8'd5: t = 9'd138; 8'd6: t = 9'd140; 8'd7: t = 9'd142;
      8'd8: t = 9'd144; 8'd9: t = 9'd146; 8'd10: t = 9'd148; 8'd11: t = 9'd150;
      8'd12: t = 9'd152; 8'd13: t = 9'd154; 8'd14: t = 9'd156; 8'd15: t = 9'd157;
      8'd16: t = 9'd159; 8'd17: t = 9'd161; 8'd18: t = 9'd163; 8'd19: t = 9'd165;
      8'd20: t = 9'd167; 8'd21: t = 9'd169; 8'd22: t = 9'd170; 8'd23: t = 9'd172;
      8'd24: t = 9'd174; 8'd25: t = 9'd176; 8'd26: t = 9'd177; 8'd27: t = 9'd179;
      8'd28: t = 9'd181; 8'd29: t = 9'd182; 8'd30: t = 9'd184; 8'd31: t = 9'd186;
      8'd32: t = 9'd187; 8'd33: t = 9'd189; 8'd34: t = 9'd190; 8'd35: t = 9'd192;
      8'd36: t = 9'd193; 8'd37: t = 9'd195; 8'd38: t = 9'd196; 8'd39: t = 9'd198;
      8'd40: t = 9'd199; 8'd41: t = 9'd200; 8'd42: t = 9'd202; 8'd43: t = 9'd203;
      8'd44: t = 9'd204; 8'd45: t = 9'd206; 8'd46: t = 9'd207; 8'd47: t = 9'd208;
      8'd48: t = 9'd209; 8'd49: t = 9'd210; 8'd50: t = 9'd212; 8'd51: t = 9'd213;
      8'd52: t = 9'd214; 8'd53: t = 9'd215; 8'd54: t = 9'd216; 8'd55: t = 9'd217;
      8'd56: t = 9'd218; 8'd57: t = 9'd219; 8'd58: t = 9'd220; 8'd59: t = 9'd221;
      8'd60: t = 9'd222; 8'd61: t = 9'd223; 8'd62: t = 9'd224; 8'd63: t = 9'd225;
      8'd64: t = 9'd225; 8'd65: t = 9'd226; 8'd66: t = 9'd227; 8'd67: t = 9'd228;
      8'd68: t = 9'd229; 8'd69: t = 9'd229; 8'd70: t = 9'd230; 8'd71: t = 9'd231;
      8'd72: t = 9'd232; 8'd73: t = 9'd232; 8'd74: t = 9'd233; 8'd75: t = 9'd234;
      8'd76: t = 9'd234; 8'd77: t = 9'd235; 8'd78: t = 9'd235; 8'd79: t = 9'd236;
      8'd80: t = 9'd237; 8'd81: t = 9'd237; 8'd82: t = 9'd238; 8'd83: t = 9'd238;
      8'd84: t = 9'd239; 8'd85: t = 9'd239; 8'd86: t = 9'd240; 8'd87: t = 9'd240;
      8'd88: t = 9'd241; 8'd89: t = 9'd241; 8'd90: t = 9'd241; 8'd91: t = 9'd242;
      8'd92: t = 9'd242; 8'd93: t = 9'd243; 8'd94: t = 9'd243; 8'd95: t = 9'd243;
      8'd96: t = 9'd244; 8'd97: t = 9'd244; 8'd98: t = 9'd245; 8'd99: t = 9'd245;
      8'd100: t = 9'd245; 8'd101: t = 9'd246; 8'd102: t = 9'd246; 8'd103: t = 9'd246;
      8'd104: t = 9'd246; 8'd105: t = 9'd247; 8'd106: t = 9'd247; 8'd107: t = 9'd247;
      8'd108: t = 9'd248; 8'd109: t = 9'd248; 8'd110: t = 9'd248; 8'd111: t = 9'd248;
      8'd112: t = 9'd248; 8'd113: t = 9'd249; 8'd114: t = 9'd249; 8'd115: t = 9'd249;
      8'd116: t = 9'd249; 8'd117: t = 9'd250; 8'd118: t = 9'd250; 8'd119: t = 9'd250;
      8'd120: t = 9'd250; 8'd121: t = 9'd250; 8'd122: t = 9'd250; 8'd123: t = 9'd251;
      8'd124: t = 9'd251; 8'd125: t = 9'd251; 8'd126: t = 9'd251; 8'd127: t = 9'd251;
      8'd128: t = 9'd251; 8'd129: t = 9'd252; 8'd130: t = 9'd252; 8'd131: t = 9'd252;
      8'd132: t = 9'd252; 8'd133: t = 9'd252; 8'd134: t = 9'd252; 8'd135: t = 9'd252;
      8'd136: t = 9'd252; 8'd137: t = 9'd253; 8'd138: t = 9'd253; 8'd139: t = 9'd253;
      8'd140: t = 9'd253; 8'd141: t = 9'd253; 8'd142: t = 9'd253; 8'd143: t = 9'd253;
      8'd144: t = 9'd253; 8'd145: t = 9'd253; 8'd146: t = 9'd253; 8'd147: t = 9'd253;
      8'd148: t = 9'd254; 8'd149: t = 9'd254; 8'd150: t = 9'd254; 8'd151: t = 9'd254;
      8'd152: t = 9'd254; 8'd153: t = 9'd254; 8'd154: t = 9'd254; 8'd155: t = 9'd254;
      8'd156: t = 9'd254; 8'd157: t = 9'd254; 8'd158: t = 9'd254; 8'd159: t = 9'd254;
      8'd160: t = 9'd254; 8'd161: t = 9'd254; 8'd162: t = 9'd254; 8'd163: t = 9'd254;
      8'd164: t = 9'd254;
      8'd165, 8'd166, 8'd167, 8'd168, 8'd169, 8'd170, 8'd171, 8'd172, 8'd173,
      8'd174, 8'd175, 8'd176, 8'd177, 8'd178, 8'd179, 8'd180, 8'd181, 8'd182,
      8'd183, 8'd184, 8'd185, 8'd186, 8'd187, 8'd188, 8'd189, 8'd190, 8'd191,
      8'd192, 8'd193, 8'd194, 8'd195, 8'd196, 8'd197, 8'd198, 8'd199: t = 9'd255;
      default: t = LUT_W'(SIG_ONE);
    endcase
  end

endmodule

// File: rtl/sigmoid_lut.sv
// Sigmoid activation: saturate outside +/-8.0, otherwise look up |x| and
// mirror the table for negative inputs. One registered stage.
module sigmoid_lut
  import activation_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] addr,
  output logic              out_valid,
  output logic [DATA_W-1:0] result
);

  localparam logic signed [DATA_W-1:0] SAT_POS = DATA_W'(SAT_LIMIT);
  localparam logic signed [DATA_W-1:0] SAT_NEG = -SAT_POS;

  logic signed [DATA_W-1:0] x;
  logic                     sat_hi;
  logic                     sat_lo;
  logic                     neg;
  logic [MAG_W-1:0]         mag;
  logic [IDX_W-1:0]         idx;
  logic [LUT_W-1:0]         t;
  logic [LUT_W-1:0]         f;

  assign x      = $signed(addr);
  assign sat_hi = (x >= SAT_POS);
  assign sat_lo = (x <= SAT_NEG);
  assign neg    = addr[DATA_W-1];

  // Only the low bits are negated: once saturation is excluded |x| < 2048,
  // so -32768 never needs a real magnitude.
  assign mag = neg ? (~addr[MAG_W-1:0] + MAG_W'(1)) : addr[MAG_W-1:0];
  assign idx = IDX_W'(mag >> LUT_IDX_LSB);

  sigmoid_rom u_rom (
    .idx (idx),
    .t   (t)
  );

  always_comb begin
    f = t;
    if (sat_hi)
      f = LUT_W'(SIG_ONE);
    else if (sat_lo)
      f = '0;
    else if (neg)
      f = LUT_W'(SIG_ONE) - t;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      result    <= {{(DATA_W-LUT_W){1'b0}}, f};
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_sigmoid_lut.sv
// Bench for sigmoid_lut: constant vectors, sweeps against a floating-point
// sigmoid model, symmetry and asynchronous reset sequences.
module tb_sigmoid_lut;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] addr;
  logic        out_valid;
  logic [15:0] result;

  sigmoid_lut dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .addr      (addr),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        iv;
    logic [15:0] er;
    logic        ev;
  } vec_t;

  typedef struct {
    logic [15:0] er;
    logic        ev;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   tmodel[256];

  function automatic int model_f(input logic [15:0] a);
    int x;
    int mag;
    x = int'($signed(a));
    if (x >= 2048) return 256;
    if (x <= -2048) return 0;
    mag = (x < 0) ? -x : x;
    return (x >= 0) ? tmodel[mag / 8] : 256 - tmodel[mag / 8];
  endfunction

  task automatic check(input string name, input logic [15:0] got_r, input logic got_v,
                       input logic [15:0] er, input logic ev);
    total++;
    if (got_r !== er || got_v !== ev) begin
      bad++;
      $display("FAIL %s: got result=%0d out_valid=%0b, want result=%0d out_valid=%0b",
               name, got_r, got_v, er, ev);
    end
  endtask

  task automatic step(input logic [15:0] a, input logic v, input logic [15:0] er,
                      input logic ev, input string name, output logic [15:0] got);
    exp_t e;
    addr = a;
    in_valid = v;
    e.er = er;
    e.ev = ev;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = result;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty at output", name);
    end else begin
      e = sb.pop_front();
      check(e.name, result, out_valid, e.er, e.ev);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[18];
    logic [15:0] got;
    logic [15:0] gp;
    logic [15:0] gn;
    logic [15:0] prev;
    int          nonmono;

    for (int k = 0; k < 256; k++)
      tmodel[k] = int'($floor(256.0 / (1.0 + $exp(-real'(k) / 32.0)) + 0.5));

    vecs[0]  = '{16'h0000, 1'b1, 16'd128, 1'b1};
    vecs[1]  = '{16'h0080, 1'b1, 16'd159, 1'b1};
    vecs[2]  = '{16'h0100, 1'b1, 16'd187, 1'b1};
    vecs[3]  = '{16'hFF00, 1'b1, 16'd69,  1'b1};
    vecs[4]  = '{16'h0800, 1'b1, 16'd256, 1'b1};
    vecs[5]  = '{16'h7FFF, 1'b1, 16'd256, 1'b1};
    vecs[6]  = '{16'hF800, 1'b1, 16'd0,   1'b1};
    vecs[7]  = '{16'h8000, 1'b1, 16'd0,   1'b1};
    vecs[8]  = '{16'h0001, 1'b1, 16'd128, 1'b1};
    vecs[9]  = '{16'hFFFF, 1'b1, 16'd128, 1'b1};
    vecs[10] = '{16'h07FF, 1'b1, 16'd256, 1'b1};
    vecs[11] = '{16'hF801, 1'b1, 16'd0,   1'b1};
    vecs[12] = '{16'hF900, 1'b1, 16'd0,   1'b1};
    vecs[13] = '{16'hFB27, 1'b1, 16'd2,   1'b1};
    vecs[14] = '{16'h0040, 1'b1, 16'd144, 1'b1};
    vecs[15] = '{16'h0060, 1'b0, 16'd152, 1'b0};
    vecs[16] = '{16'hFFC0, 1'b1, 16'd112, 1'b1};
    vecs[17] = '{16'h0020, 1'b1, 16'd136, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    addr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", result, out_valid, 16'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++)
      step(vecs[i].addr, vecs[i].iv, vecs[i].er, vecs[i].ev, $sformatf("vec%0d", i), got);

    nonmono = 0;
    prev = 16'd0;
    for (int a = 63744; a <= 64295; a++) begin
      step(16'(a), 1'b1, 16'(model_f(16'(a))), 1'b1, $sformatf("sweep_%0d", a), got);
      if (a > 63744 && got < prev) nonmono++;
      prev = got;
    end
    total++;
    if (nonmono != 0) begin
      bad++;
      $display("FAIL sweep_monotone: got %0d decreasing steps, want 0", nonmono);
    end

    for (int x = 1; x < 2048; x++) begin
      step(16'(x), 1'b1, 16'(model_f(16'(x))), 1'b1, $sformatf("sym_pos_%0d", x), gp);
      step(16'(-x), 1'b1, 16'(model_f(16'(-x))), 1'b1, $sformatf("sym_neg_%0d", x), gn);
      total++;
      if (int'(gp) + int'(gn) != 256) begin
        bad++;
        $display("FAIL symmetry_%0d: got sum=%0d, want 256", x, int'(gp) + int'(gn));
      end
    end

    // Asynchronous reset in the middle of a cycle, away from any clock edge.
    step(16'h0100, 1'b1, 16'd187, 1'b1, "pre_reset", got);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("async_reset", result, out_valid, 16'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", result, out_valid, 16'd0, 1'b0);
    rst = 1'b0;
    step(16'h0100, 1'b0, 16'd187, 1'b0, "post_reset_idle", got);
    step(16'hFF00, 1'b1, 16'd69, 1'b1, "post_reset_valid", got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
